// File: rtl/memory_map_pkg.sv
// rtl/memory_map_pkg.sv - address map, register offsets and status bit positions for memory_responder
package memory_map_pkg;

   localparam int RAM_ADDR_BITS_DEFAULT = 14;

   localparam logic [15:0] MMIO_BASE     = 16'hFF00;
   localparam logic [15:0] OFS_LED       = 16'h0000;
   localparam logic [15:0] OFS_SWITCHES  = 16'h0001;
   localparam logic [15:0] OFS_TIMER_LO  = 16'h0002;
   localparam logic [15:0] OFS_TIMER_HI  = 16'h0003;
   localparam logic [15:0] OFS_STATUS    = 16'h0004;
   localparam logic [15:0] OFS_PUSH      = 16'h0005;

   localparam logic [15:0] ADDR_LED      = MMIO_BASE + OFS_LED;
   localparam logic [15:0] ADDR_SWITCHES = MMIO_BASE + OFS_SWITCHES;
   localparam logic [15:0] ADDR_TIMER_LO = MMIO_BASE + OFS_TIMER_LO;
   localparam logic [15:0] ADDR_TIMER_HI = MMIO_BASE + OFS_TIMER_HI;
   localparam logic [15:0] ADDR_STATUS   = MMIO_BASE + OFS_STATUS;
   localparam logic [15:0] ADDR_PUSH     = MMIO_BASE + OFS_PUSH;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_COUNT_LSB = 4;

   typedef enum logic {
      SEL_MMIO = 1'b0,
      SEL_RAM  = 1'b1
   } read_sel_e;

   function automatic logic in_ram(input logic [15:0] addr, input int addr_bits);
      return (addr >> addr_bits) == 16'h0000;
   endfunction

endpackage

// File: rtl/memory_ram.sv
// rtl/memory_ram.sv - single-port block RAM, synchronous read returning old data on read-during-write
module memory_ram #(
   parameter int ADDR_BITS = 14,
   parameter int DATA_BITS = 16
) (
   input  logic                 clock,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic                 we,
   input  logic [DATA_BITS-1:0] wdata,
   output logic [DATA_BITS-1:0] rdata
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - CPU bus target: block RAM, LED/switch/status MMIO and push-only output FIFO
// Optional cycle timer at 0xFF02/0xFF03 is built only when TIMER_EN is defined.
module memory_responder
   import memory_map_pkg::*;
#(
   parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEFAULT,
   parameter int LED_WIDTH     = 10,
   parameter int SW_WIDTH      = 10,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [15:0]          memory_address,
   input  logic                 memory_write_enable,
   input  logic [15:0]          memory_write_data,
   output logic [15:0]          memory_read_data,
   input  logic [SW_WIDTH-1:0]  switches,
   output logic [LED_WIDTH-1:0] leds,
   output logic                 out_valid,
   output logic [15:0]          out_data,
   input  logic                 out_ready
);

   localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic                     ram_hit;
   logic [15:0]              ram_rdata;
   read_sel_e                rd_sel;
   logic [15:0]              mmio_rdata;
   logic [15:0]              mmio_q;
   logic [SW_WIDTH-1:0]      sw_meta;
   logic [SW_WIDTH-1:0]      sw_sync;
   logic [15:0]              led_ext;
   logic [15:0]              sw_ext;
   logic [15:0]              status_word;
   logic [15:0]              timer_lo;
   logic [15:0]              timer_hi;

   logic [15:0]              fifo_mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]      wr_ptr;
   logic [PTR_BITS-1:0]      rd_ptr;
   logic [3:0]               count;
   logic                     overflow;
   logic                     full;
   logic                     empty;
   logic                     push;
   logic                     pop;
   logic                     accept;

   assign ram_hit = in_ram(memory_address, RAM_ADDR_BITS);

   memory_ram #(
      .ADDR_BITS(RAM_ADDR_BITS),
      .DATA_BITS(16)
   ) u_ram (
      .clock(clock),
      .addr (memory_address[RAM_ADDR_BITS-1:0]),
      .we   (memory_write_enable && ram_hit),
      .wdata(memory_write_data),
      .rdata(ram_rdata)
   );

   assign full   = (count == 4'(FIFO_DEPTH));
   assign empty  = (count == 4'd0);
   assign push   = memory_write_enable && (memory_address == ADDR_PUSH);
   assign pop    = out_valid && out_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign accept = push && (!full || pop);

   assign out_valid = !empty;
   assign out_data  = empty ? 16'h0000 : fifo_mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= 4'd0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            count <= count + 4'd1;
         end else if (pop && !accept) begin
            count <= count - 4'd1;
         end
         if (memory_write_enable && (memory_address == ADDR_STATUS)) begin
            overflow <= 1'b0;
         end else if (push && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         fifo_mem[wr_ptr] <= memory_write_data;
      end
   end

`ifdef TIMER_EN
   logic [31:0] timer;
   logic [15:0] shadow;

   // Reading the low half latches the high half so software sees a coherent 32-bit pair.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer  <= 32'd0;
         shadow <= 16'd0;
      end else if (memory_write_enable && (memory_address == ADDR_TIMER_LO)) begin
         timer  <= 32'd0;
         shadow <= 16'd0;
      end else begin
         timer <= timer + 32'd1;
         if (memory_address == ADDR_TIMER_LO) begin
            shadow <= timer[31:16];
         end
      end
   end

   assign timer_lo = timer[15:0];
   assign timer_hi = shadow;
`else
   assign timer_lo = 16'h0000;
   assign timer_hi = 16'h0000;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         leds    <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switches;
         sw_sync <= sw_meta;
         if (memory_write_enable && (memory_address == ADDR_LED)) begin
            leds <= memory_write_data[LED_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      led_ext                  = '0;
      led_ext[LED_WIDTH-1:0]   = leds;
      sw_ext                   = '0;
      sw_ext[SW_WIDTH-1:0]     = sw_sync;
      status_word              = '0;
      status_word[ST_FULL]     = full;
      status_word[ST_EMPTY]    = empty;
      status_word[ST_OVERFLOW] = overflow;
      status_word[ST_COUNT_LSB +: 4] = count;
   end

   always_comb begin
      mmio_rdata = 16'h0000;
      case (memory_address)
         ADDR_LED:      mmio_rdata = led_ext;
         ADDR_SWITCHES: mmio_rdata = sw_ext;
         ADDR_TIMER_LO: mmio_rdata = timer_lo;
         ADDR_TIMER_HI: mmio_rdata = timer_hi;
         ADDR_STATUS:   mmio_rdata = status_word;
         default:       mmio_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_sel <= SEL_MMIO;
         mmio_q <= 16'h0000;
      end else begin
         rd_sel <= ram_hit ? SEL_RAM : SEL_MMIO;
         mmio_q <= mmio_rdata;
      end
   end

   assign memory_read_data = (rd_sel == SEL_RAM) ? ram_rdata : mmio_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed/randomized bench for memory_responder against a queue/array model
module tb_memory_responder;

   localparam int DEPTH = 4;

   logic        clock;
   logic        reset;
   logic [15:0] memory_address;
   logic        memory_write_enable;
   logic [15:0] memory_write_data;
   logic [15:0] memory_read_data;
   logic [9:0]  switches;
   logic [9:0]  leds;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] ram_model [int];
   logic [15:0] fifo_q [$];
   logic        ovf_model;
   logic [9:0]  led_model;

   memory_responder dut (
      .clock              (clock),
      .reset              (reset),
      .memory_address     (memory_address),
      .memory_write_enable(memory_write_enable),
      .memory_write_data  (memory_write_data),
      .memory_read_data   (memory_read_data),
      .switches           (switches),
      .leds               (leds),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_ready          (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
      @(negedge clock);
      memory_address      = addr;
      memory_write_data   = data;
      memory_write_enable = 1'b1;
      @(negedge clock);
      memory_write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
      @(negedge clock);
      memory_address      = addr;
      memory_write_enable = 1'b0;
      @(negedge clock);
      data = memory_read_data;
   endtask

   function automatic logic [15:0] status_exp(input int size, input logic ovf);
      return 16'((size << 4) | (int'(ovf) << 2) | (int'(size == 0) << 1) | int'(size == DEPTH));
   endfunction

   // Model pushes: queue grows up to DEPTH, extra pushes set the sticky overflow.
   task automatic model_push(input logic [15:0] data);
      if (fifo_q.size() < DEPTH) fifo_q.push_back(data);
      else ovf_model = 1'b1;
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] v;
      logic [15:0] old_sw;
      logic [15:0] last_out;
      int          a;

      reset               = 1'b0;
      memory_address      = 16'h0000;
      memory_write_enable = 1'b0;
      memory_write_data   = 16'h0000;
      switches            = 10'h000;
      out_ready           = 1'b0;
      ovf_model           = 1'b0;
      led_model           = 10'h000;

      repeat (2) @(negedge clock);
      check("rst_read_data", memory_read_data, 16'h0000);
      check("rst_leds", leds, 10'h000);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 16'h0000);
      reset = 1'b1;

      // RAM: fixed word, then random words read back in a different order
      bus_write(16'h0010, 16'h1234);
      ram_model[16'h0010] = 16'h1234;
      bus_read(16'h0010, rd);
      check("ram_0010", rd, 16'h1234);
      for (int i = 0; i < 8; i++) begin
         a = int'($urandom_range(0, 16'h3FFF));
         v = 16'($urandom);
         bus_write(16'(a), v);
         ram_model[a] = v;
      end
      foreach (ram_model[k]) begin
         bus_read(16'(k), rd);
         check($sformatf("ram_%04h", k), rd, ram_model[k]);
      end
      bus_read(16'h4000, rd);
      check("ram_top_plus1", rd, 16'h0000);
      bus_read(16'hFFFF, rd);
      check("unmapped_ffff", rd, 16'h0000);

      // read during write returns the previous contents
      @(negedge clock);
      v = 16'($urandom);
      memory_address      = 16'h0010;
      memory_write_data   = v;
      memory_write_enable = 1'b1;
      @(negedge clock);
      memory_write_enable = 1'b0;
      check("rdw_old", memory_read_data, ram_model[16'h0010]);
      ram_model[16'h0010] = v;
      bus_read(16'h0010, rd);
      check("rdw_new", rd, v);

      // LEDs
      bus_write(16'hFF00, 16'h03FF);
      check("leds_3ff", leds, 10'h3FF);
      bus_read(16'hFF00, rd);
      check("led_read_3ff", rd, 16'h03FF);
      v = 16'($urandom);
      bus_write(16'hFF00, v);
      led_model = v[9:0];
      check("leds_rand", leds, led_model);
      bus_read(16'hFF00, rd);
      check("led_read_rand", rd, {6'd0, led_model});
      bus_write(16'hFF01, 16'hFFFF);
      check("leds_ro_write_ignored", leds, led_model);

      // switches through the synchronizer
      switches = 10'h155;
      repeat (3) @(negedge clock);
      bus_read(16'hFF01, rd);
      check("sw_155", rd, 16'h0155);
      old_sw = rd;
      switches = 10'(~10'h155);
      @(negedge clock);
      check("sw_stale1", memory_read_data, old_sw);
      @(negedge clock);
      check("sw_stale2", memory_read_data, old_sw);
      @(negedge clock);
      check("sw_new", memory_read_data, 16'h02AA);

`ifdef TIMER_EN
      bus_write(16'hFF02, 16'h0000);
      repeat (100) @(negedge clock);
      bus_read(16'hFF02, rd);
      check("timer_lo_range", 32'(rd >= 16'd100 && rd <= 16'd103), 32'd1);
      bus_read(16'hFF03, rd);
      check("timer_hi_zero", rd, 16'h0000);
      repeat (65536) @(negedge clock);
      bus_read(16'hFF02, rd);
      bus_read(16'hFF03, rd);
      check("timer_hi_wrapped", rd, 16'h0001);
`else
      bus_read(16'hFF02, rd);
      check("timer_lo_absent", rd, 16'h0000);
      bus_read(16'hFF03, rd);
      check("timer_hi_absent", rd, 16'h0000);
`endif
      bus_read(16'hFF05, rd);
      check("push_reg_reads_zero", rd, 16'h0000);
      bus_read(16'hFF06, rd);
      check("unmapped_ff06", rd, 16'h0000);

      // FIFO overflow and clear
      bus_read(16'hFF04, rd);
      check("status_empty", rd, status_exp(0, 1'b0));
      for (int i = 0; i < 5; i++) begin
         v = 16'($urandom);
         bus_write(16'hFF05, v);
         model_push(v);
      end
      bus_read(16'hFF04, rd);
      check("status_full_ovf", rd, status_exp(fifo_q.size(), ovf_model));
      check("head_valid", out_valid, 1'b1);
      check("head_data", out_data, fifo_q[0]);
      bus_write(16'hFF04, 16'h0000);
      ovf_model = 1'b0;
      bus_read(16'hFF04, rd);
      check("status_ovf_cleared", rd, status_exp(fifo_q.size(), ovf_model));

      // push into full FIFO while the head leaves
      @(negedge clock);
      memory_address      = 16'hFF05;
      memory_write_data   = 16'hBEEF;
      memory_write_enable = 1'b1;
      out_ready           = 1'b1;
      check("pre_pop_head", out_data, fifo_q[0]);
      void'(fifo_q.pop_front());
      fifo_q.push_back(16'hBEEF);
      @(negedge clock);
      memory_write_enable = 1'b0;
      out_ready           = 1'b0;
      bus_read(16'hFF04, rd);
      check("status_push_pop_full", rd, status_exp(fifo_q.size(), ovf_model));
      out_ready = 1'b1;
      last_out  = 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("drain_valid_%0d", i), out_valid, 1'b1);
         check($sformatf("drain_data_%0d", i), out_data, fifo_q[0]);
         last_out = out_data;
         void'(fifo_q.pop_front());
         @(negedge clock);
      end
      out_ready = 1'b0;
      check("beef_last", last_out, 16'hBEEF);
      check("drained_valid", out_valid, 1'b0);
      check("drained_data", out_data, 16'h0000);

      // random push/ready traffic
      @(negedge clock);
      for (int i = 0; i < 40; i++) begin
         logic p;
         logic r;
         p = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         v = 16'($urandom);
         memory_address      = p ? 16'hFF05 : 16'h0000;
         memory_write_enable = p;
         memory_write_data   = v;
         out_ready           = r;
         check($sformatf("rand_valid_%0d", i), out_valid, 1'(fifo_q.size() != 0));
         check($sformatf("rand_data_%0d", i), out_data, (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000);
         if (r && fifo_q.size() != 0) void'(fifo_q.pop_front());
         if (p) model_push(v);
         @(negedge clock);
      end
      memory_write_enable = 1'b0;
      out_ready           = 1'b0;
      bus_read(16'hFF04, rd);
      check("status_after_random", rd, status_exp(fifo_q.size(), ovf_model));

      // asynchronous reset in the middle of a drain
      for (int i = 0; i < 2; i++) begin
         v = 16'($urandom);
         bus_write(16'hFF05, v);
         model_push(v);
      end
      bus_write(16'hFF00, 16'h02A5);
      bus_read(16'hFF00, rd);
      check("led_before_reset", rd, 16'h02A5);
      out_ready = 1'b1;
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_read_data", memory_read_data, 16'h0000);
      check("reset_out_data", out_data, 16'h0000);
      check("reset_leds", leds, 10'h000);
      fifo_q.delete();
      ovf_model = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      bus_read(16'hFF04, rd);
      check("status_after_reset", rd, status_exp(0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
